// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch handshake and next-PC sequencer
module fetch_sequencer #(
    parameter int                 ADDR_W   = 8,
    parameter int                 INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic                o_imem_req,
    output logic [ADDR_W-1:0]   o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [INSTR_W-1:0]  i_imem_rdata,
    output logic [INSTR_W-1:0]  o_instr,
    output logic                o_instr_valid,
    output logic [ADDR_W-1:0]   o_pc,
    output logic [ADDR_W-1:0]   o_pc_plus1,
    input  logic [2:0]          i_pcsrc,
    input  logic [ADDR_W-1:0]   i_branch_off,
    input  logic [ADDR_W-1:0]   i_jump_target,
    input  logic [ADDR_W-1:0]   i_reg_target,
    input  logic                i_stall,
    output logic                o_illegal
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_req;
    logic                r_illegal;

    logic [ADDR_W-1:0]   w_pc_plus1;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_reserved;

    assign w_pc_plus1 = r_pc + ADDR_W'(1);

    // Two's-complement add makes the signed branch offset wrap for free.
    always_comb begin
        w_next_pc  = w_pc_plus1;
        w_reserved = 1'b0;
        case (i_pcsrc)
            3'b000, 3'b001: w_next_pc = w_pc_plus1;
            3'b010:         w_next_pc = w_pc_plus1 + i_branch_off;
            3'b110:         w_next_pc = i_reg_target;
            3'b111:         w_next_pc = i_jump_target;
            default:        w_reserved = 1'b1;
        endcase
    end

    // The request flop resets low, so the cycle right after reset is a dead FETCH cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_req     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (r_req && i_imem_ack) begin
                        r_instr <= i_imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_EXEC;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (!i_stall) begin
                        r_pc      <= w_next_pc;
                        r_req     <= 1'b1;
                        r_illegal <= w_reserved;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = (r_state == S_EXEC);
    assign o_pc          = r_pc;
    assign o_pc_plus1    = w_pc_plus1;
    assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_rdata;
    logic [15:0] o_instr;
    logic        o_instr_valid;
    logic [7:0]  o_pc;
    logic [7:0]  o_pc_plus1;
    logic [2:0]  i_pcsrc;
    logic [7:0]  i_branch_off;
    logic [7:0]  i_jump_target;
    logic [7:0]  i_reg_target;
    logic        i_stall;
    logic        o_illegal;

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .o_pc          (o_pc),
        .o_pc_plus1    (o_pc_plus1),
        .i_pcsrc       (i_pcsrc),
        .i_branch_off  (i_branch_off),
        .i_jump_target (i_jump_target),
        .i_reg_target  (i_reg_target),
        .i_stall       (i_stall),
        .o_illegal     (o_illegal)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mem [256];
    logic [7:0]  mpc;
    logic [15:0] m_instr;
    bit          exp_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next PC from the instruction-set rules, using plain integer arithmetic.
    function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [2:0] src,
                                              input logic [7:0] off, input logic [7:0] jt,
                                              input logic [7:0] rt, output bit ill);
        int v;
        ill = 1'b0;
        v = int'(pc) + 1;
        case (src)
            3'd2: v = v + ((off >= 8'd128) ? int'(off) - 256 : int'(off));
            3'd6: v = int'(rt);
            3'd7: v = int'(jt);
            3'd3, 3'd4, 3'd5: ill = 1'b1;
            default: ;
        endcase
        v = ((v % 256) + 256) % 256;
        return v[7:0];
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!o_imem_req && n < 4) begin
            tick();
            n++;
        end
        check("req_rise", o_imem_req, 1);
    endtask

    // One instruction: d ack-delay cycles, s stall cycles, then exit with the given select.
    task automatic run(input int d, input int s, input logic [2:0] src, input logic [7:0] off,
                       input logic [7:0] jt, input logic [7:0] rt);
        logic [7:0] p1;
        bit ill;
        for (int k = 0; k <= d; k++) begin
            check("f_req", o_imem_req, 1);
            check("f_addr", o_imem_addr, mpc);
            check("f_valid", o_instr_valid, 0);
            check("f_instr_hold", o_instr, m_instr);
            check("f_illegal", o_illegal, (k == 0) ? 32'(exp_ill) : 32'd0);
            i_stall      = 1'($urandom_range(0, 1));
            i_imem_ack   = (k == d);
            i_imem_rdata = (k == d) ? mem[mpc] : 16'($urandom);
            tick();
        end
        i_imem_ack = 1'b0;
        m_instr    = mem[mpc];
        p1         = mpc + 8'd1;
        for (int j = 0; j <= s; j++) begin
            check("e_valid", o_instr_valid, 1);
            check("e_req", o_imem_req, 0);
            check("e_instr", o_instr, m_instr);
            check("e_pc", o_pc, mpc);
            check("e_pc_plus1", o_pc_plus1, p1);
            check("e_illegal", o_illegal, 0);
            i_stall = (j < s);
            if (j < s) begin
                i_pcsrc       = 3'($urandom);
                i_branch_off  = 8'($urandom);
                i_jump_target = 8'($urandom);
                i_reg_target  = 8'($urandom);
            end else begin
                i_pcsrc       = src;
                i_branch_off  = off;
                i_jump_target = jt;
                i_reg_target  = rt;
            end
            tick();
        end
        i_stall = 1'b0;
        mpc     = model_next(mpc, src, off, jt, rt, ill);
        exp_ill = ill;
    endtask

    task automatic go_to(input logic [7:0] a);
        run(0, 0, 3'd7, 8'h00, a, 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        i_reset = 1'b1; i_imem_ack = 1'b0; i_imem_rdata = '0; i_pcsrc = '0;
        i_branch_off = '0; i_jump_target = '0; i_reg_target = '0; i_stall = 1'b0;
        mpc = 8'h00; m_instr = 16'h0000; exp_ill = 1'b0;
        tick(); tick();
        check("rst_req", o_imem_req, 0);
        check("rst_valid", o_instr_valid, 0);
        check("rst_instr", o_instr, 0);
        check("rst_pc", o_pc, 0);
        check("rst_illegal", o_illegal, 0);
        i_reset = 1'b0;
        wait_req();
        check("first_addr", o_imem_addr, 8'h00);

        run(0, 0, 3'd0, 0, 0, 0); check("seq1", o_imem_addr, 8'h01);
        run(0, 0, 3'd0, 0, 0, 0); check("seq2", o_imem_addr, 8'h02);
        run(0, 0, 3'd0, 0, 0, 0); check("seq3", o_imem_addr, 8'h03);
        go_to(8'hFF);
        run(0, 0, 3'd1, 0, 0, 0); check("wrap", o_imem_addr, 8'h00);
        go_to(8'h10); run(0, 0, 3'd2, 8'hFC, 0, 0); check("br_back", o_pc, 8'h0D);
        go_to(8'h10); run(0, 0, 3'd2, 8'h05, 0, 0); check("br_fwd", o_pc, 8'h16);
        go_to(8'h10); run(0, 0, 3'd0, 8'h05, 0, 0); check("br_none", o_pc, 8'h11);
        go_to(8'h20); run(0, 0, 3'd7, 0, 8'h80, 8'h44); check("jmp", o_pc, 8'h80);
        go_to(8'h20); run(0, 0, 3'd6, 0, 8'h80, 8'h44); check("rts", o_pc, 8'h44);
        run(3, 2, 3'd0, 0, 0, 0);
        go_to(8'h30); run(0, 0, 3'd4, 0, 0, 0);
        check("rsv_pc", o_pc, 8'h31);
        check("rsv_ill", o_illegal, 1);
        run(0, 0, 3'd0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            run($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Reset while a request is outstanding; a stale ack must not land in instr.
        i_imem_ack = 1'b0;
        i_reset = 1'b1;
        #1;
        check("rstf_req_async", o_imem_req, 0);
        i_imem_ack = 1'b1; i_imem_rdata = 16'hBEEF;
        tick(); tick();
        check("rstf_instr", o_instr, 0);
        check("rstf_pc", o_pc, 0);
        i_reset = 1'b0;
        tick();
        check("rstf_stale_ack", o_instr, 0);
        i_imem_ack = 1'b0;
        mpc = 8'h00; m_instr = 16'h0000; exp_ill = 1'b0;
        wait_req();
        check("rstf_addr", o_imem_addr, 8'h00);

        // Reset in EXEC with a reserved select pending: no PC update, no pulse.
        go_to(8'h40);
        i_imem_ack = 1'b1; i_imem_rdata = mem[8'h40];
        tick();
        i_imem_ack = 1'b0;
        check("rste_valid", o_instr_valid, 1);
        i_pcsrc = 3'b100; i_stall = 1'b0; i_reset = 1'b1;
        #1;
        check("rste_valid_drop", o_instr_valid, 0);
        tick();
        check("rste_ill", o_illegal, 0);
        check("rste_pc", o_pc, 0);
        i_reset = 1'b0;
        tick();
        check("rste_ill2", o_illegal, 0);
        mpc = 8'h00; m_instr = 16'h0000; exp_ill = 1'b0;
        wait_req();
        run(1, 1, 3'd0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
